// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_SAT_EN to saturate the sum to signed max/min on overflow.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             pg,
    output logic             gg
);

    localparam int NG = WIDTH / 4;

    // Group propagate/generate of one 4-bit lookahead block: {PG, GG}
    function automatic logic [1:0] grp_pg(input logic [3:0] p, input logic [3:0] g);
        logic gp;
        logic gn;
        gp = &p;
        gn = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        return {gp, gn};
    endfunction

    // Carries into each bit of a 4-bit block, all looked ahead from ci
    function automatic logic [3:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    logic [NG-1:0]    gp_d;
    logic [NG-1:0]    gg_d;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gp;
    logic [NG-1:0]    s1_gg;
    logic             s1_c0;
`ifdef CLA_SAT_EN
    logic             s1_sign;
`endif

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH:0]   c;
    logic             word_g;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    // Stage 2 takes a new entry when empty or when its result leaves
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Operand conditioning and per-bit / per-group propagate-generate
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;
        p_d   = a ^ b_eff;
        g_d   = a & b_eff;
        gp_d  = '0;
        gg_d  = '0;
        for (int k = 0; k < NG; k++) begin
            {gp_d[k], gg_d[k]} = grp_pg(p_d[4*k +: 4], g_d[4*k +: 4]);
        end
    end

    // Stage 1 register: p/g terms, group terms and carry-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
`ifdef CLA_SAT_EN
            s1_sign  <= 1'b0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_p    <= p_d;
                s1_g    <= g_d;
                s1_gp   <= gp_d;
                s1_gg   <= gg_d;
                s1_c0   <= c0;
`ifdef CLA_SAT_EN
                s1_sign <= a[WIDTH-1];
`endif
            end
        end
    end

    // Group carry chain, in-group lookahead carries and word generate
    always_comb begin : s2_carry
        logic cg;
        logic gw;
        cg = s1_c0;
        gw = 1'b0;
        c  = '0;
        for (int k = 0; k < NG; k++) begin
            c[4*k +: 4] = grp_carry(s1_p[4*k +: 4], s1_g[4*k +: 4], cg);
            cg = s1_gg[k] | (s1_gp[k] & cg);
            gw = s1_gg[k] | (s1_gp[k] & gw);
        end
        c[WIDTH] = cg;
        word_g   = gw;
    end

    // Sum bits, overflow and optional saturation
    always_comb begin
        sum_d = s1_p ^ c[WIDTH-1:0];
        ovf_d = c[WIDTH] ^ c[WIDTH-1];
`ifdef CLA_SAT_EN
        if (ovf_d) begin
            sum_d = s1_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage 2 register: result held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            pg        <= 1'b0;
            gg        <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_d;
                cout <= c[WIDTH];
                ovf  <= ovf_d;
                pg   <= &s1_gp;
                gg   <= word_g;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: table vectors, stall/reset sequences,
// random streaming at WIDTH=16 and exhaustive streaming at WIDTH=4.
module tb_cla_pipe_adder;

`ifdef CLA_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        pg;
        logic        gg;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum_wrap;
        logic [15:0] sum_sat;
        logic        cout;
        logic        ovf;
        logic        pg;
        logic        gg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, sum16;
    logic        cin16, sub16, cout16, ovf16, pg16, gg16;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, sub4, cout4, ovf4, pg4, gg4;

    int vectors = 0;
    int miscompares = 0;
    int n_out16 = 0;
    int n_out4 = 0;
    res_t q16[$];
    res_t q4[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .pg(pg16), .gg(gg16)
    );

    cla_pipe_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .pg(pg4), .gg(gg4)
    );

    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic s);
        res_t r;
        int unsigned m, av, be, c0, full, sa, sb, sr;
        m    = (32'd1 << w) - 1;
        av   = 32'(a) & m;
        be   = s ? (~32'(b) & m) : (32'(b) & m);
        c0   = s ? 1 : 32'(ci);
        full = av + be + c0;
        r.sum  = 16'(full & m);
        r.cout = ((full >> w) & 1) != 0;
        sa = (av >> (w - 1)) & 1;
        sb = (be >> (w - 1)) & 1;
        sr = (32'(r.sum) >> (w - 1)) & 1;
        r.ovf = (sa == sb) && (sr != sa);
        r.pg  = ((av ^ be) & m) == m;
        r.gg  = (((av + be) >> w) & 1) != 0;
        if (SAT && r.ovf) begin
            r.sum = (sa != 0) ? 16'(32'd1 << (w - 1)) : 16'((32'd1 << (w - 1)) - 1);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_res(input string nm, input res_t got, input res_t exp);
        chk({nm, " sum"},  32'(got.sum),  32'(exp.sum));
        chk({nm, " cout"}, 32'(got.cout), 32'(exp.cout));
        chk({nm, " ovf"},  32'(got.ovf),  32'(exp.ovf));
        chk({nm, " pg"},   32'(got.pg),   32'(exp.pg));
        chk({nm, " gg"},   32'(got.gg),   32'(exp.gg));
    endtask

    // One cycle on the 16-bit DUT: drive, settle, score the transfers of the coming edge
    task automatic cyc16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s, input logic ordy, output logic acc);
        res_t e;
        @(negedge clk);
        in_valid16 = v; a16 = a; b16 = b; cin16 = ci; sub16 = s;
        out_ready16 = ordy;
        #1;
        if (out_valid16 && out_ready16) begin
            n_out16++;
            if (q16.size() == 0) begin
                chk("w16 unexpected output", 32'(out_valid16), 32'd0);
            end else begin
                e = q16.pop_front();
                chk_res("w16 stream", {sum16, cout16, ovf16, pg16, gg16}, e);
            end
        end
        acc = in_valid16 && in_ready16;
        if (acc) q16.push_back(model(16, a, b, ci, s));
    endtask

    task automatic cyc4(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic s, input logic ordy, output logic acc);
        res_t e;
        @(negedge clk);
        in_valid4 = v; a4 = a; b4 = b; cin4 = ci; sub4 = s;
        out_ready4 = ordy;
        #1;
        if (out_valid4 && out_ready4) begin
            n_out4++;
            if (q4.size() == 0) begin
                chk("w4 unexpected output", 32'(out_valid4), 32'd0);
            end else begin
                e = q4.pop_front();
                chk_res("w4 stream", {12'd0, sum4, cout4, ovf4, pg4, gg4}, e);
            end
        end
        acc = in_valid4 && in_ready4;
        if (acc) q4.push_back(model(4, {12'd0, a}, {12'd0, b}, ci, s));
    endtask

    vec_t tab[10];

    initial begin
        logic acc;
        res_t ea, exp_t;
        int idx, cycles, base;

        tab[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[2] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[3] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[6] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[8] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[9] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; out_ready16 = 0;
        in_valid4 = 0;  a4 = '0;  b4 = '0;  cin4 = 0;  sub4 = 0;  out_ready4 = 0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid16), 32'd0);
        chk_res("reset", {sum16, cout16, ovf16, pg16, gg16}, '0);
        chk("reset w4 out_valid", 32'(out_valid4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready16), 32'd1);

        // table vectors with exact two-cycle latency
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a16 = tab[i].a; b16 = tab[i].b; cin16 = tab[i].cin; sub16 = tab[i].sub;
            in_valid16 = 1; out_ready16 = 1;
            #1;
            chk($sformatf("tab%0d in_ready", i), 32'(in_ready16), 32'd1);
            @(negedge clk);
            in_valid16 = 0;
            #1;
            chk($sformatf("tab%0d lat1 out_valid", i), 32'(out_valid16), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("tab%0d lat2 out_valid", i), 32'(out_valid16), 32'd1);
            exp_t.sum  = SAT ? tab[i].sum_sat : tab[i].sum_wrap;
            exp_t.cout = tab[i].cout;
            exp_t.ovf  = tab[i].ovf;
            exp_t.pg   = tab[i].pg;
            exp_t.gg   = tab[i].gg;
            chk_res($sformatf("tab%0d", i), {sum16, cout16, ovf16, pg16, gg16}, exp_t);
        end
        @(negedge clk);

        // three back-to-back ops into a stalled output
        ea = model(16, 16'h1111, 16'h2222, 1'b0, 1'b0);
        cyc16(1, 16'h1111, 16'h2222, 0, 0, 0, acc);
        chk("stall accept A", 32'(acc), 32'd1);
        cyc16(1, 16'h7000, 16'h7000, 0, 0, 0, acc);
        chk("stall accept B", 32'(acc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc16(1, 16'h0010, 16'h0020, 1, 1, 0, acc);
            chk("stall in_ready low", 32'(acc), 32'd0);
            chk("stall out_valid", 32'(out_valid16), 32'd1);
            chk_res("stall hold", {sum16, cout16, ovf16, pg16, gg16}, ea);
        end
        base = n_out16;
        cyc16(1, 16'h0010, 16'h0020, 1, 1, 1, acc);
        chk("accept while emitting", 32'(acc), 32'd1);
        cyc16(0, 16'h0, 16'h0, 0, 0, 1, acc);
        cyc16(0, 16'h0, 16'h0, 0, 0, 1, acc);
        chk("stall drain count", 32'(n_out16 - base), 32'd3);
        chk("stall queue empty", 32'(q16.size()), 32'd0);

        // random streaming at WIDTH=16
        for (int i = 0; i < 300; i++) begin
            cyc16($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 10 && q16.size() != 0; i++) begin
            cyc16(0, 16'h0, 16'h0, 0, 0, 1, acc);
        end
        chk("random queue empty", 32'(q16.size()), 32'd0);

        // reset with both stages full
        cyc16(1, 16'h0100, 16'h0200, 0, 0, 0, acc);
        cyc16(1, 16'h0300, 16'h0400, 0, 0, 0, acc);
        @(negedge clk);
        chk("full before reset", 32'(out_valid16), 32'd1);
        rst_n = 1'b0;
        in_valid16 = 1; a16 = 16'hDEAD; b16 = 16'hBEEF;
        #1;
        chk("reset clears out_valid", 32'(out_valid16), 32'd0);
        q16.delete();
        @(negedge clk);
        in_valid16 = 0;
        rst_n = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready16), 32'd1);
        base = n_out16;
        cyc16(1, 16'h0042, 16'h0001, 0, 1, 1, acc);
        for (int i = 0; i < 6; i++) begin
            cyc16(0, 16'h0, 16'h0, 0, 0, 1, acc);
        end
        chk("post-reset result count", 32'(n_out16 - base), 32'd1);
        chk("post-reset queue empty", 32'(q16.size()), 32'd0);

        // exhaustive WIDTH=4 stream with random handshakes
        idx = 0;
        cycles = 0;
        while (idx < 1024 && cycles < 20000) begin
            cyc4($urandom_range(0, 3) != 0, 4'(idx >> 6), 4'(idx >> 2),
                 1'(idx >> 1), 1'(idx), $urandom_range(0, 2) != 0, acc);
            if (acc) idx++;
            cycles++;
        end
        chk("w4 all accepted", 32'(idx), 32'd1024);
        for (int i = 0; i < 20 && q4.size() != 0; i++) begin
            cyc4(0, 4'h0, 4'h0, 0, 0, 1, acc);
        end
        chk("w4 queue empty", 32'(q4.size()), 32'd0);
        chk("w4 result count", 32'(n_out4), 32'd1024);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
